seq_div_tc: RTL and testbench
=============================

// Module: seq_div_tc
// PURPOSE
//   Sequential two's-complement divider; the inverse of the array4tc multiplier.
//   Takes a 2N-bit signed dividend (product width) and an N-bit signed divisor.
//   Returns an N-bit quotient truncated toward zero and an N-bit remainder.
//   Restoring division on magnitudes, one quotient bit per clock; Start/Busy/Done handshake.
// PARAMETERS
//   N   4   operand width; dividend A is 2N bits, divisor/quotient/remainder N bits
// PORTS
//   Clk      in   1    clock; all state on rising edge
//   Reset_n  in   1    asynchronous, active-low reset
//   Start    in   1    request; sampled only in IDLE
//   A        in   2N   signed dividend, captured with Start
//   B        in   N    signed divisor, captured with Start
//   Busy     out  1    high in DIV and FIX states
//   Done     out  1    one-cycle pulse; Q/R/flags valid from this cycle
//   Q        out  N    signed quotient, trunc toward zero
//   R        out  N    signed remainder; R = A - Q*B, sign(R) = sign(A) or R = 0
//   DivZero  out  1    B == 0 on last accepted op
//   Ovf      out  1    true quotient outside [-2^(N-1), 2^(N-1)-1]
// BEHAVIOUR
//   Reset (async, Reset_n=0): state IDLE; Busy, Done, Q, R, DivZero, Ovf all 0.
//   FSM: IDLE -Start-> DIV (N cycles, bit counter N-1..0) -> FIX -> DONE -> IDLE.
//   Latency: Done high N+2 rising edges after the edge that samples Start (N=4: 6).
//   Start while Busy or in DONE: ignored, no effect on the op in flight.
//   On accept: latch sA=A[2N-1], sB=B[N-1], |A| (2N bits), |B| (N bits).
//     Negating -2^(2N-1) or -2^(N-1) yields the unsigned magnitude 2^(2N-1) / 2^(N-1).
//   DIV: partial remainder P (N+1 bits) starts at |A| top N bits.
//     Each cycle: shift in the next |A| bit; if P >= |B| then subtract and set q bit = 1.
//   FIX: Q = (sA^sB) ? -qmag : qmag; R = sA ? -rmag : rmag.
//     Q, R, flags register on the FIX->DONE edge.
//   Outputs hold until the next op's FIX->DONE edge; they do not clear on return to IDLE.
//   B == 0: DivZero=1, Ovf=0, Q={N{1'b1}}, R=A[N-1:0]; same latency.
//   Reset mid-op: immediate return to IDLE; all outputs cleared; in-flight op lost.
// CONFIGURATION
//   DIVTC_OVF_CHECK_EN defined:
//     Ovf=1 if |A| top N bits >= |B| (checked at accept),
//     or if unsigned quotient qmag exceeds the signed range for the result sign
//     (qmag > 2^(N-1)-1 when positive, qmag > 2^(N-1) when negative).
//     On Ovf: Q=0, R=0.
//   Not defined: Ovf tied 0. Q/R are undefined when the true quotient does not fit
//     (the bench must not check them); latency is unchanged.
// STRUCTURE
//   Package divtc_pkg: state enum {IDLE, DIV, FIX, DONE};
//     localparam DIVTC_N_DEF = 4; counter-width function clog2.
//   Sub-module divtc_abs (combinational, width parameter W): magnitude and negate helper.
//     Instantiated for |A| (W=2N), |B| (W=N), and the FIX-state sign correction.
//   Top level: FSM, counter, P/quotient shift registers, output registers.
// TESTING (N=4; check Done exactly 6 edges after Start)
//   A=8'hE1(-31), B=4'h7 -> Q=4'hC(-4), R=4'hD(-3), DivZero=0, Ovf=0
//   A=8'h15(21), B=4'hD(-3) -> Q=4'h9(-7), R=4'h0
//   A=8'hE0(-32), B=4'h4 -> Q=4'h8(-8), Ovf=0 (edge of range)
//   With DIVTC_OVF_CHECK_EN: A=8'h40, B=4'h3 -> Ovf=1 (hi check);
//     A=8'hC0(-64), B=4'h8(-8) -> Ovf=1 (quotient +8); both give Q=0, R=0
//   A=8'h25, B=4'h0 -> DivZero=1, Q=4'hF, R=4'h5
//   Start pulsed while Busy ignored; Reset_n low at DIV cycle 2 -> all outputs 0, Done never pulses

Source files
------------

// File: rtl/divtc_pkg.sv
// Shared definitions for the seq_div_tc sequential two's-complement divider.
//   DIVTC_N_DEF   : default operand width N
//   divtc_state_e : controller states IDLE -> DIV -> FIX -> DONE
//   clog2()       : counter width helper for elaboration-time sizing
package divtc_pkg;

    localparam int DIVTC_N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } divtc_state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/divtc_abs.sv
// Combinational conditional negate for W-bit two's-complement values.
// Used both as an absolute-value unit (neg tied to the sign bit) and as the
// sign-correction stage for the quotient and remainder.
//   val [W-1:0] in  : operand
//   neg         in  : 1 = output the two's-complement negation of val
//   res [W-1:0] out : val or -val; the most negative input maps to its
//                     unsigned magnitude 2^(W-1), which is the same bit pattern
module divtc_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/seq_div_tc.sv
// Sequential two's-complement divider: 2N-bit signed dividend A by N-bit
// signed divisor B, producing an N-bit quotient truncated toward zero and an
// N-bit remainder carrying the sign of A. Restoring division on magnitudes,
// one quotient bit per clock, Start/Busy/Done handshake.
// Optional feature macro: DIVTC_OVF_CHECK_EN (quotient overflow detection;
// when undefined Ovf is tied low and out-of-range quotients are undefined).
//   Clk      in  : clock, rising edge
//   Reset_n  in  : asynchronous active-low reset
//   Start    in  : operation request, sampled only in IDLE
//   A [2N]   in  : signed dividend, captured with Start
//   B [N]    in  : signed divisor, captured with Start
//   Busy     out : high in DIV and FIX
//   Done     out : one-cycle pulse, results valid from this cycle
//   Q [N]    out : signed quotient
//   R [N]    out : signed remainder
//   DivZero  out : divisor of last accepted op was zero
//   Ovf      out : quotient did not fit the signed N-bit range
module seq_div_tc
    import divtc_pkg::*;
#(
    parameter int N = DIVTC_N_DEF
) (
    input  logic           Clk,
    input  logic           Reset_n,
    input  logic           Start,
    input  logic [2*N-1:0] A,
    input  logic [N-1:0]   B,
    output logic           Busy,
    output logic           Done,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           DivZero,
    output logic           Ovf
);

    localparam int CW = (N > 1) ? clog2(N) : 1;
`ifdef DIVTC_OVF_CHECK_EN
    localparam logic [N-1:0] Q_POS_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] Q_NEG_MAX = {1'b1, {(N-1){1'b0}}};
`endif

    divtc_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic          bz_q, bz_d;
    logic [N-1:0]  alo_q, alo_d;     // low half of |A|, fed into P one bit per cycle
    logic [N-1:0]  absb_q, absb_d;
    logic [N-1:0]  araw_q, araw_d;   // raw A[N-1:0], returned as R on divide-by-zero
    logic [N:0]    p_q, p_d;         // partial remainder
    logic [N-1:0]  qm_q, qm_d;       // quotient magnitude, shifted in MSB first
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          ovf_q, ovf_d;
`ifdef DIVTC_OVF_CHECK_EN
    logic          hi_q, hi_d;       // top half of |A| already >= |B|: quotient exceeds N bits
    logic          ovf_now;
`endif

    logic [2*N-1:0] abs_a;
    logic [N-1:0]   abs_b;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;
    logic [N:0]     p_shift;
    logic [N:0]     p_sub;
    logic           ge;

    divtc_abs #(.W(2*N)) u_abs_a (.val(A),              .neg(A[2*N-1]),     .res(abs_a));
    divtc_abs #(.W(N))   u_abs_b (.val(B),              .neg(B[N-1]),       .res(abs_b));
    divtc_abs #(.W(N))   u_fix_q (.val(qm_q),           .neg(sa_q ^ sb_q),  .res(q_fix));
    divtc_abs #(.W(N))   u_fix_r (.val(p_q[N-1:0]),     .neg(sa_q),         .res(r_fix));

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    assign p_shift = {p_q[N-1:0], alo_q[cnt_q]};
    assign ge      = (p_shift >= {1'b0, absb_q});
    assign p_sub   = p_shift - {1'b0, absb_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        alo_d   = alo_q;
        absb_d  = absb_q;
        araw_d  = araw_q;
        p_d     = p_q;
        qm_d    = qm_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
`ifdef DIVTC_OVF_CHECK_EN
        hi_d    = hi_q;
        ovf_now = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = DIV;
                    cnt_d   = CW'(N-1);
                    sa_d    = A[2*N-1];
                    sb_d    = B[N-1];
                    bz_d    = (B == '0);
                    alo_d   = abs_a[N-1:0];
                    absb_d  = abs_b;
                    araw_d  = A[N-1:0];
                    p_d     = {1'b0, abs_a[2*N-1:N]};
                    qm_d    = '0;
`ifdef DIVTC_OVF_CHECK_EN
                    hi_d    = (abs_a[2*N-1:N] >= abs_b);
`endif
                end
            end
            DIV: begin
                p_d  = ge ? p_sub : p_shift;
                qm_d = {qm_q[N-2:0], ge};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                state_d = DONE;
                if (bz_q) begin
                    q_d   = '1;
                    r_d   = araw_q;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else begin
                    q_d   = q_fix;
                    r_d   = r_fix;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
`ifdef DIVTC_OVF_CHECK_EN
                    // A negative result may reach magnitude 2^(N-1); a positive one may not.
                    ovf_now = hi_q | ((sa_q ^ sb_q) ? (qm_q > Q_NEG_MAX) : (qm_q > Q_POS_MAX));
                    ovf_d   = ovf_now;
                    if (ovf_now) begin
                        q_d = '0;
                        r_d = '0;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            alo_q   <= '0;
            absb_q  <= '0;
            araw_q  <= '0;
            p_q     <= '0;
            qm_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef DIVTC_OVF_CHECK_EN
            hi_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            alo_q   <= alo_d;
            absb_q  <= absb_d;
            araw_q  <= araw_d;
            p_q     <= p_d;
            qm_q    <= qm_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
`ifdef DIVTC_OVF_CHECK_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign Busy    = (state_q == DIV) || (state_q == FIX);
    assign Done    = (state_q == DONE);
    assign Q       = q_q;
    assign R       = r_q;
    assign DivZero = dz_q;
    assign Ovf     = ovf_q;

endmodule

// File: tb/tb_seq_div_tc.sv
// Directed testbench for seq_div_tc with N=4.
// Stimulus: hand-computed division vectors, divide-by-zero, Start while busy
// and in DONE, output hold in IDLE, and reset in the middle of an operation.
// Overflow vectors are exercised when DIVTC_OVF_CHECK_EN is defined.
module tb_seq_div_tc;

    localparam int N = 4;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Start;
    logic [7:0] A;
    logic [3:0] B;
    logic       Busy;
    logic       Done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       DivZero;
    logic       Ovf;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    seq_div_tc #(.N(N)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Q       (Q),
        .R       (R),
        .DivZero (DivZero),
        .Ovf     (Ovf)
    );

    // Launch one op; k counts rising edges after the accepting edge, sampled on
    // the falling edge before edge k. Optionally pulse Start while busy (k=2)
    // and while in DONE (k=6) with a different operand pair.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, input bit inject,
                         output int lat, output int busy_cnt, output int done_cnt,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic dz, output logic ov);
        @(negedge Clk);
        A = a; B = b; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0; A = 8'h00; B = 4'h0;
        lat = -1; busy_cnt = 0; done_cnt = 0;
        q = 4'hx; r = 4'hx; dz = 1'bx; ov = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (lat < 0) begin
                    lat = k; q = Q; r = R; dz = DivZero; ov = Ovf;
                end
            end
            if (inject && (k == 2 || k == 6)) begin A = 8'h7F; B = 4'h1; Start = 1'b1; end
            if (inject && (k == 3 || k == 7)) begin Start = 1'b0; end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Start = 1'b0; A = 8'h00; B = 4'h0;
        repeat (2) @(negedge Clk);
        total++;
        if ({Busy, Done, Q, R, DivZero, Ovf} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 000", {Busy, Done, Q, R, DivZero, Ovf});
        end
        Reset_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_basic();
        int lat, bc, dc; logic [3:0] q, r; logic dz, ov;
        // -31 / 7 -> -4 rem -3
        do_op(8'hE1, 4'h7, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL m31d7_latency: got %0d expected 6", lat); end
        total++; if (bc !== 5) begin bad++; $display("FAIL m31d7_busy_cycles: got %0d expected 5", bc); end
        total++; if (dc !== 1) begin bad++; $display("FAIL m31d7_done_pulses: got %0d expected 1", dc); end
        total++; if (q !== 4'hC) begin bad++; $display("FAIL m31d7_q: got %h expected c", q); end
        total++; if (r !== 4'hD) begin bad++; $display("FAIL m31d7_r: got %h expected d", r); end
        total++; if ({dz, ov} !== 2'b00) begin bad++; $display("FAIL m31d7_flags: got %b expected 00", {dz, ov}); end
        // 21 / -3 -> -7 rem 0
        do_op(8'h15, 4'hD, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL 21dm3_latency: got %0d expected 6", lat); end
        total++; if (q !== 4'h9) begin bad++; $display("FAIL 21dm3_q: got %h expected 9", q); end
        total++; if (r !== 4'h0) begin bad++; $display("FAIL 21dm3_r: got %h expected 0", r); end
        // -32 / 4 -> -8, edge of range
        do_op(8'hE0, 4'h4, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL m32d4_latency: got %0d expected 6", lat); end
        total++; if (q !== 4'h8) begin bad++; $display("FAIL m32d4_q: got %h expected 8", q); end
        total++; if (r !== 4'h0) begin bad++; $display("FAIL m32d4_r: got %h expected 0", r); end
        total++; if ({dz, ov} !== 2'b00) begin bad++; $display("FAIL m32d4_flags: got %b expected 00", {dz, ov}); end
    endtask

    task automatic test_divzero();
        int lat, bc, dc; logic [3:0] q, r; logic dz, ov;
        do_op(8'h25, 4'h0, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL dz_latency: got %0d expected 6", lat); end
        total++; if (q !== 4'hF) begin bad++; $display("FAIL dz_q: got %h expected f", q); end
        total++; if (r !== 4'h5) begin bad++; $display("FAIL dz_r: got %h expected 5", r); end
        total++; if ({dz, ov} !== 2'b10) begin bad++; $display("FAIL dz_flags: got %b expected 10", {dz, ov}); end
        // DivZero must drop on the next normal op
        do_op(8'h15, 4'hD, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if ({dz, q} !== 5'b0_1001) begin bad++; $display("FAIL dz_clear: got %b expected 01001", {dz, q}); end
    endtask

    task automatic test_ovf();
`ifdef DIVTC_OVF_CHECK_EN
        int lat, bc, dc; logic [3:0] q, r; logic dz, ov;
        // 64 / 3: top half 4 >= 3
        do_op(8'h40, 4'h3, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL ovf_hi_latency: got %0d expected 6", lat); end
        total++; if ({ov, dz, q, r} !== 10'b10_0000_0000) begin bad++; $display("FAIL ovf_hi: got %b expected 1000000000", {ov, dz, q, r}); end
        // -64 / -8 = +8, exceeds +7
        do_op(8'hC0, 4'h8, 1'b0, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL ovf_pos8_latency: got %0d expected 6", lat); end
        total++; if ({ov, dz, q, r} !== 10'b10_0000_0000) begin bad++; $display("FAIL ovf_pos8: got %b expected 1000000000", {ov, dz, q, r}); end
`endif
    endtask

    task automatic test_back_to_back();
        int lat, bc, dc; logic [3:0] q, r; logic dz, ov;
        do_op(8'hE1, 4'h7, 1'b1, lat, bc, dc, q, r, dz, ov);
        total++; if (lat !== 6) begin bad++; $display("FAIL busy_start_latency: got %0d expected 6", lat); end
        total++; if (dc !== 1) begin bad++; $display("FAIL busy_start_done_pulses: got %0d expected 1", dc); end
        total++; if ({q, r} !== 8'hCD) begin bad++; $display("FAIL busy_start_result: got %h expected cd", {q, r}); end
    endtask

    task automatic test_hold();
        repeat (5) @(negedge Clk);
        total++;
        if ({Done, Busy, Q, R, DivZero, Ovf} !== 12'b00_1100_1101_00) begin
            bad++;
            $display("FAIL idle_hold: got %b expected 001100110100", {Done, Busy, Q, R, DivZero, Ovf});
        end
    endtask

    task automatic test_reset_mid_op();
        int dc, bc;
        @(negedge Clk);
        A = 8'h15; B = 4'hD; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        total++;
        if ({Busy, Done, Q, R, DivZero, Ovf} !== 12'h000) begin
            bad++;
            $display("FAIL midop_reset_outputs: got %h expected 000", {Busy, Done, Q, R, DivZero, Ovf});
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        dc = 0; bc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            if (Done) dc++;
            if (Busy) bc++;
        end
        total++; if ({dc, bc} !== {32'd0, 32'd0}) begin bad++; $display("FAIL midop_lost: done=%0d busy=%0d expected 0 0", dc, bc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_divzero();
        test_ovf();
        test_back_to_back();
        test_hold();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
